// File: rtl/ram_block_mover_if.sv
`default_nettype none
// ============================================================================
// ram_block_mover_if : control handshake and RAM port bundle for ram_block_mover
// Revision: 1.0
// ============================================================================
interface ram_block_mover_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [DW-1:0] fill_val;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_address;
  logic          mem_load;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out;

  // The mover owns the RAM port and answers the control handshake.
  modport master (
    input  start, mode, src, dst, len, fill_val, mem_out,
    output busy, done, mem_address, mem_load, mem_in
  );

  // Controller / RAM side of the same bundle.
  modport slave (
    output start, mode, src, dst, len, fill_val, mem_out,
    input  busy, done, mem_address, mem_load, mem_in
  );
endinterface
`default_nettype wire

// File: rtl/ram_block_mover.sv
`default_nettype none
// ============================================================================
// ram_block_mover : block copy / block fill master for a single-port 4096x16 RAM
// Revision: 1.0
// ============================================================================
module ram_block_mover #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              reset,
  ram_block_mover_if.master bus_io
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [AW:0]   c_cnt_one = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   c_cnt_max = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] c_ptr_one = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q;
  logic [AW-1:0] src_ptr_q;
  logic [AW-1:0] dst_ptr_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] mem_address_q;
  logic [DW-1:0] mem_in_q;
  logic          mem_load_q;
  logic          busy_q;
  logic          done_q;

  logic [AW-1:0] src_ptr_d;
  logic [AW-1:0] dst_ptr_d;
  logic [AW:0]   count_d;
  logic [AW:0]   len_sat_d;
  logic          last_d;

  always_comb begin
    src_ptr_d = src_ptr_q + c_ptr_one;
    dst_ptr_d = dst_ptr_q + c_ptr_one;
    count_d   = count_q - c_cnt_one;
    last_d    = (count_q == c_cnt_one);
    // Any encoding with the top bit set means a full-memory job.
    len_sat_d = bus_io.len[AW] ? c_cnt_max : bus_io.len;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      src_ptr_q     <= '0;
      dst_ptr_q     <= '0;
      count_q       <= '0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
      mem_load_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q     <= 1'b0;
          mem_load_q <= 1'b0;
          if (bus_io.start) begin
            src_ptr_q <= bus_io.src;
            dst_ptr_q <= bus_io.dst;
            count_q   <= len_sat_d;
            mem_in_q  <= bus_io.fill_val;
            busy_q    <= 1'b1;
            if (bus_io.len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (!bus_io.mode) begin
              state_q       <= S_RD;
              mem_address_q <= bus_io.src;
            end else begin
              state_q       <= S_FILL;
              mem_address_q <= bus_io.dst;
              mem_load_q    <= 1'b1;
            end
          end
        end

        S_RD: begin
          state_q       <= S_WR;
          mem_address_q <= dst_ptr_q;
          mem_load_q    <= 1'b1;
        end

        S_WR: begin
          src_ptr_q <= src_ptr_d;
          dst_ptr_q <= dst_ptr_d;
          count_q   <= count_d;
          if (last_d) begin
            state_q    <= S_DONE;
            mem_load_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            state_q       <= S_RD;
            mem_address_q <= src_ptr_d;
            mem_load_q    <= 1'b0;
          end
        end

        S_FILL: begin
          dst_ptr_q <= dst_ptr_d;
          count_q   <= count_d;
          if (last_d) begin
            state_q    <= S_DONE;
            mem_load_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            mem_address_q <= dst_ptr_d;
          end
        end

        S_DONE: begin
          state_q    <= S_IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          mem_load_q <= 1'b0;
        end

        default: begin
          state_q    <= S_IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          mem_load_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.busy        = busy_q;
  assign bus_io.done        = done_q;
  assign bus_io.mem_address = mem_address_q;
  assign bus_io.mem_load    = mem_load_q;
  // The RAM's read data only appears during WR, so it is forwarded straight to the write port.
  assign bus_io.mem_in      = (state_q == S_WR) ? bus_io.mem_out : mem_in_q;

endmodule
`default_nettype wire
